rotsq_sequencer: RTL and testbench
==================================

// Module: rotsq_sequencer
// PURPOSE
//  Controller that sequences the rotating-square animation on the 8-digit seven-segment display.
//  One 8-state position machine replaces the separate CW/CCW animators and their output muxes.
//  Prescaled step timing, run-time direction, pause and manual single-step.
//  Drives an/sseg directly at top level.
//  Raises a one-cycle lap pulse each time the square completes a full loop.
// PARAMETERS
//  N        28   prescaler width; auto step every 2**N enabled clk cycles
// PORTS
//  clk        in   1  system clock; sole clock domain
//  rst        in   1  synchronous, active-high reset
//  en         in   1  1 = prescaler runs (auto-step); 0 = paused, display held
//  direction  in   1  1 = clockwise, 0 = counter-clockwise; sampled only at a step
//  step       in   1  single-cycle pulse: advance one position now, even while en=0
//  an         out  8  digit enables, active-low; an[7:4] always 4'b1111
//  sseg       out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1
//  pos        out  3  current position 0..7, for debug/LEDs
//  lap        out  1  one-cycle pulse on a loop wrap
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): cnt=0, pos=0, an=8'hF7, sseg=8'h9C, lap=0.
//   rst has priority over every other input.
//  Prescaler: cnt (N bits) increments on each clk with en=1; holds when en=0.
//   tick = en && (cnt == 2**N-1); cnt wraps to 0 on the tick edge.
//  Advance: adv = tick | step. Simultaneous tick and step produce ONE advance, not two.
//   step does not alter cnt.
//  Position machine, 8 states P0..P7:
//   P0..P3: upper square (a,b,f,g lit; sseg=8'h9C) on digits 3,2,1,0.
//   P4..P7: lower square (c,d,e,g lit; sseg=8'hA3) on digits 0,1,2,3.
//   direction=1: Pk -> P(k+1 mod 8). direction=0: Pk -> P(k-1 mod 8).
//   Without adv, pos holds.
//  Direction is read only on the adv edge.
//   Toggles between steps are ignored unless still present at the step.
//   No glitching of the pattern.
//  Digit map: an[3:0] has one zero at the digit for pos; e.g. P0 -> 4'b0111, P3 -> 4'b1110,
//   P4 -> 4'b1110, P7 -> 4'b0111.
//  Outputs: an, sseg, pos and lap are registered.
//   They are decoded from next-pos and update on the same edge as pos, so latency from adv to display is 0 cycles.
//  lap: asserted for the single cycle after an adv edge that took P7->P0 (CW) or P0->P7 (CCW); otherwise 0.
//  Pause: en=0 freezes cnt and pos; display keeps the current square lit (not blanked).
//  Reset mid-interval: cnt and pos clear immediately; a pending tick or step in that cycle is discarded.
// STRUCTURE
//  Package rotsq_pkg:
//   typedef enum logic [2:0] pos_t {P0..P7}
//   localparams SSEG_UPPER=8'h9C, SSEG_LOWER=8'hA3, AN_HI_OFF=4'b1111
//   function an_of(pos_t) returning the 4-bit digit mask
//  Sub-module tick_gen #(N): en in, tick out, cnt internal. Reused by other timed display blocks.
//  rotsq_sequencer holds the position FSM, direction sampling, output decode registers and lap logic.
// TESTING  (bench uses N=3, so a tick occurs every 8 enabled cycles)
//  1 Reset: rst=1 for 2 clk -> an=8'hF7, sseg=8'h9C, pos=0, lap=0; hold en=0 for 20 clk -> no change.
//  2 CW run: en=1, direction=1 -> pos becomes 1 on the 8th enabled edge (an=8'hFB, sseg=9C).
//     At pos=4 expect an=8'hFE, sseg=8'hA3.
//     After 64 edges pos=0 and lap has pulsed exactly once, for 1 cycle.
//  3 CCW wrap: from reset, en=1, direction=0 -> first tick gives pos=7, an=8'hF7, sseg=8'hA3, lap=1 for 1 cycle.
//  4 Direction mid-interval: CW, toggle direction to 0 at cnt=3, back to 1 at cnt=5 -> next tick still CW (pos+1).
//     Toggle held through the tick -> pos-1.
//  5 Pause/step: en=0, step pulse -> pos+1 on that edge, cnt unchanged.
//     step coincident with a tick (en=1, cnt=7) -> pos advances by exactly 1.
//  6 Reset mid-operation: rst=1 at pos=5, cnt=6 -> next edge pos=0, an=8'hF7, sseg=8'h9C.
//     After release, first tick comes 8 enabled cycles later.

Source files
------------

// File: rtl/rotsq_pkg.sv
// rtl/rotsq_pkg.sv - shared types, display constants and digit decode for the rotating square
package rotsq_pkg;

    typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5, P6, P7} pos_t;

    localparam logic [7:0] SSEG_UPPER = 8'h9C;
    localparam logic [7:0] SSEG_LOWER = 8'hA3;
    localparam logic [3:0] AN_HI_OFF  = 4'b1111;

    // Upper square walks digits 3->0, lower square walks back 0->3.
    function automatic logic [3:0] an_of(input pos_t p);
        logic [3:0] mask;
        case (p)
            P0, P7:  mask = 4'b0111;
            P1, P6:  mask = 4'b1011;
            P2, P5:  mask = 4'b1101;
            default: mask = 4'b1110;
        endcase
        return mask;
    endfunction

    function automatic logic [7:0] sseg_of(input pos_t p);
        return p[2] ? SSEG_LOWER : SSEG_UPPER;
    endfunction

endpackage

// File: rtl/rotsq_sequencer_if.sv
// rtl/rotsq_sequencer_if.sv - control inputs and display outputs of the rotating-square sequencer
interface rotsq_sequencer_if;
    logic       en;
    logic       direction;
    logic       step;
    logic [7:0] an;
    logic [7:0] sseg;
    logic [2:0] pos;
    logic       lap;

    modport master (
        output en, direction, step,
        input  an, sseg, pos, lap
    );

    modport slave (
        input  en, direction, step,
        output an, sseg, pos, lap
    );
endinterface

// File: rtl/rotsq_sequencer_tick_gen.sv
// rtl/rotsq_sequencer_tick_gen.sv - free-running prescaler, one tick every 2**N enabled cycles
module tick_gen #(
    parameter int N = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [N-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == {N{1'b1}});

endmodule

// File: rtl/rotsq_sequencer.sv
// rtl/rotsq_sequencer.sv - position machine, direction sampling and registered display decode
module rotsq_sequencer
    import rotsq_pkg::*;
#(
    parameter int N = 28
) (
    input  logic              clk,
    input  logic              rst,
    rotsq_sequencer_if.slave  bus
);

    pos_t       state;
    pos_t       state_nxt;
    logic       tick;
    logic       adv;
    logic       wrap;
    logic [7:0] an_q;
    logic [7:0] sseg_q;
    logic       lap_q;

    tick_gen #(.N(N)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .tick (tick)
    );

    // A tick and a step landing together still make only one move.
    assign adv = tick | bus.step;

    always_comb begin
        state_nxt = state;
        wrap      = 1'b0;
        if (adv) begin
            if (bus.direction) begin
                state_nxt = pos_t'(state + 3'd1);
                wrap      = (state == P7);
            end else begin
                state_nxt = pos_t'(state - 3'd1);
                wrap      = (state == P0);
            end
        end
    end

    // Outputs decode next-pos so the display moves on the same edge as pos.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= P0;
            an_q   <= {AN_HI_OFF, an_of(P0)};
            sseg_q <= SSEG_UPPER;
            lap_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            an_q   <= {AN_HI_OFF, an_of(state_nxt)};
            sseg_q <= sseg_of(state_nxt);
            lap_q  <= adv && wrap;
        end
    end

    assign bus.an   = an_q;
    assign bus.sseg = sseg_q;
    assign bus.pos  = state;
    assign bus.lap  = lap_q;

endmodule

// File: tb/tb_rotsq_sequencer.sv
// tb/tb_rotsq_sequencer.sv - self-checking bench for rotsq_sequencer with N=3
module tb_rotsq_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   checking = 1'b0;

    rotsq_sequencer_if sif ();

    rotsq_sequencer #(.N(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: integer counter and position with modulo arithmetic.
    int m_cnt = 0;
    int m_pos = 0;
    int m_lap = 0;

    always @(posedge clk) begin : model
        automatic bit m_adv;
        if (rst) begin
            m_cnt <= 0;
            m_pos <= 0;
            m_lap <= 0;
        end else begin
            m_adv = (sif.en && m_cnt == 7) || sif.step;
            if (sif.en) m_cnt <= (m_cnt + 1) % 8;
            if (m_adv) m_pos <= sif.direction ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
            m_lap <= (m_adv && ((sif.direction && m_pos == 7) || (!sif.direction && m_pos == 0))) ? 1 : 0;
        end
    end

    function automatic logic [7:0] exp_an(int p);
        int digit;
        digit = (p < 4) ? (3 - p) : (p - 4);
        return 8'hFF & ~(8'd1 << digit);
    endfunction

    function automatic logic [7:0] exp_sseg(int p);
        return (p < 4) ? 8'h9C : 8'hA3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model_pos",  {29'd0, sif.pos}, m_pos);
            chk("model_an",   {24'd0, sif.an}, {24'd0, exp_an(m_pos)});
            chk("model_sseg", {24'd0, sif.sseg}, {24'd0, exp_sseg(m_pos)});
            chk("model_lap",  {31'd0, sif.lap}, m_lap);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin : stim
        int laps;
        sif.en = 1'b0;
        sif.direction = 1'b1;
        sif.step = 1'b0;

        // 1 reset and idle hold
        cyc(2);
        checking = 1'b1;
        chk("rst_an",   {24'd0, sif.an},   32'hF7);
        chk("rst_sseg", {24'd0, sif.sseg}, 32'h9C);
        chk("rst_pos",  {29'd0, sif.pos},  32'd0);
        chk("rst_lap",  {31'd0, sif.lap},  32'd0);
        rst = 1'b0;
        cyc(20);
        chk("idle_pos", {29'd0, sif.pos}, 32'd0);
        chk("idle_an",  {24'd0, sif.an},  32'hF7);

        // 2 clockwise run
        sif.en = 1'b1;
        sif.direction = 1'b1;
        laps = 0;
        for (int i = 1; i <= 64; i++) begin
            cyc(1);
            laps += int'(sif.lap);
            if (i == 7) chk("cw_before_tick", {29'd0, sif.pos}, 32'd0);
            if (i == 8) begin
                chk("cw_first_pos",  {29'd0, sif.pos},  32'd1);
                chk("cw_first_an",   {24'd0, sif.an},   32'hFB);
                chk("cw_first_sseg", {24'd0, sif.sseg}, 32'h9C);
            end
            if (i == 32) begin
                chk("cw_p4_pos",  {29'd0, sif.pos},  32'd4);
                chk("cw_p4_an",   {24'd0, sif.an},   32'hFE);
                chk("cw_p4_sseg", {24'd0, sif.sseg}, 32'hA3);
            end
        end
        chk("cw_64_pos",  {29'd0, sif.pos}, 32'd0);
        chk("cw_64_lap",  {31'd0, sif.lap}, 32'd1);
        chk("cw_lap_cnt", laps, 32'd1);
        cyc(1);
        chk("cw_lap_gone", {31'd0, sif.lap}, 32'd0);

        // 3 counter-clockwise wrap from reset
        do_reset();
        sif.direction = 1'b0;
        cyc(8);
        chk("ccw_pos",  {29'd0, sif.pos},  32'd7);
        chk("ccw_an",   {24'd0, sif.an},   32'hF7);
        chk("ccw_sseg", {24'd0, sif.sseg}, 32'hA3);
        chk("ccw_lap",  {31'd0, sif.lap},  32'd1);
        cyc(1);
        chk("ccw_lap_gone", {31'd0, sif.lap}, 32'd0);

        // 4 direction toggles between ticks
        sif.direction = 1'b1;
        do_reset();
        cyc(3);
        sif.direction = 1'b0;
        cyc(2);
        sif.direction = 1'b1;
        cyc(3);
        chk("dir_glitch_ignored", {29'd0, sif.pos}, 32'd1);
        cyc(3);
        sif.direction = 1'b0;
        cyc(5);
        chk("dir_held_ccw", {29'd0, sif.pos}, 32'd0);
        chk("dir_no_lap",   {31'd0, sif.lap}, 32'd0);

        // 5 pause with manual step, then step coincident with tick
        sif.direction = 1'b1;
        sif.en = 1'b0;
        cyc(2);
        sif.step = 1'b1;
        cyc(1);
        sif.step = 1'b0;
        chk("step_paused", {29'd0, sif.pos}, 32'd1);
        cyc(5);
        chk("paused_hold", {29'd0, sif.pos}, 32'd1);
        sif.en = 1'b1;
        cyc(7);
        chk("pre_coincide", {29'd0, sif.pos}, 32'd1);
        sif.step = 1'b1;
        cyc(1);
        sif.step = 1'b0;
        chk("step_tick_once", {29'd0, sif.pos}, 32'd2);
        cyc(7);
        chk("cnt_untouched_hold", {29'd0, sif.pos}, 32'd2);
        cyc(1);
        chk("cnt_untouched_tick", {29'd0, sif.pos}, 32'd3);

        // 6 reset mid-interval at pos=5, cnt=6
        cyc(16);
        cyc(6);
        chk("pre_rst_pos", {29'd0, sif.pos}, 32'd5);
        do_reset();
        chk("midrst_pos",  {29'd0, sif.pos},  32'd0);
        chk("midrst_an",   {24'd0, sif.an},   32'hF7);
        chk("midrst_sseg", {24'd0, sif.sseg}, 32'h9C);
        cyc(7);
        chk("post_rst_hold", {29'd0, sif.pos}, 32'd0);
        cyc(1);
        chk("post_rst_tick", {29'd0, sif.pos}, 32'd1);

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
